// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA raster path.
package vga_pkg;

  localparam int CNT_W     = 12;
  localparam int COLOR_W   = 8;
  localparam int MAX_TOTAL = (1 << CNT_W) - 1;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // The DAC must see black outside the visible window.
  function automatic rgb_t blank_rgb(input rgb_t c, input logic blank);
    return blank ? '0 : c;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Blanking/request interface between the timing master and the framebuffer source.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic               fb_hblank;
  logic               fb_vblank;
  logic               next_n;
  logic               frame_start;
  logic [CNT_W-1:0]   pix_x;
  logic [CNT_W-1:0]   pix_y;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;

  modport master (
    output fb_hblank, fb_vblank, next_n, frame_start, pix_x, pix_y,
    input  red, green, blue
  );

  modport slave (
    input  fb_hblank, fb_vblank, next_n, frame_start, pix_x, pix_y,
    output red, green, blue
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running position counter with active/sync window decode.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap,
  output logic             active,
  output logic             sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [CNT_W-1:0] C_LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] C_ACTIVE     = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] C_SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] C_SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

  if (TOTAL > MAX_TOTAL) begin : g_total_check
    $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, CNT_W);
  end

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign cnt    = r_cnt;
  assign wrap   = en && (r_cnt == C_LAST);
  assign active = (r_cnt < C_ACTIVE);
  assign sync   = (r_cnt >= C_SYNC_START) && (r_cnt < C_SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing master: counters, registered blanking/request decode, and
// sync/colour realignment for the DAC pins.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic                vga_clk,
  input  logic                reset,
  vga_timing_gen_if.master    fb,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic [COLOR_W-1:0]  vga_r,
  output logic [COLOR_W-1:0]  vga_g,
  output logic [COLOR_W-1:0]  vga_b
);

  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_h_active;
  logic             w_v_active;
  logic             w_h_sync;
  logic             w_v_sync;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_h_axis (
    .clk    (vga_clk),
    .reset  (reset),
    .en     (1'b1),
    .cnt    (w_h_cnt),
    .wrap   (w_h_wrap),
    .active (w_h_active),
    .sync   (w_h_sync)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_v_axis (
    .clk    (vga_clk),
    .reset  (reset),
    .en     (w_h_wrap),
    .cnt    (w_v_cnt),
    .wrap   (w_v_wrap),
    .active (w_v_active),
    .sync   (w_v_sync)
  );

  // High while the counters sit at (0,0): after reset or after a full-frame wrap.
  logic r_at_origin;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_at_origin <= 1'b1;
    end else begin
      r_at_origin <= w_h_wrap & w_v_wrap;
    end
  end

  // Stage 1: registered decode of the counter state.
  logic             r_fb_hblank;
  logic             r_fb_vblank;
  logic             r_next_n;
  logic             r_frame_start;
  logic [CNT_W-1:0] r_pix_x;
  logic [CNT_W-1:0] r_pix_y;
  logic             r_hsync_raw;
  logic             r_vsync_raw;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_fb_hblank   <= 1'b1;
      r_fb_vblank   <= 1'b1;
      r_next_n      <= 1'b1;
      r_frame_start <= 1'b0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_hsync_raw   <= 1'b0;
      r_vsync_raw   <= 1'b0;
    end else begin
      r_fb_hblank   <= ~w_h_active;
      r_fb_vblank   <= ~w_v_active;
      r_next_n      <= ~(w_h_active & w_v_active);
      r_frame_start <= r_at_origin;
      r_pix_x       <= w_h_cnt;
      r_pix_y       <= w_v_cnt;
      r_hsync_raw   <= w_h_sync;
      r_vsync_raw   <= w_v_sync;
    end
  end

  assign fb.fb_hblank   = r_fb_hblank;
  assign fb.fb_vblank   = r_fb_vblank;
  assign fb.next_n      = r_next_n;
  assign fb.frame_start = r_frame_start;
  assign fb.pix_x       = r_pix_x;
  assign fb.pix_y       = r_pix_y;

  logic w_hs_level;
  logic w_vs_level;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_hs_level = ~HS_POL;
    w_vs_level = ~VS_POL;
    if (r_hsync_raw) w_hs_level = HS_POL;
    if (r_vsync_raw) w_vs_level = VS_POL;
  end

  // Stage 2: the source registers colour one clock after the request, so the
  // request and syncs are delayed by one to line up with it.
  logic r_next_n_d;
  logic r_vga_hs;
  logic r_vga_vs;

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      r_next_n_d <= 1'b1;
      r_vga_hs   <= ~HS_POL;
      r_vga_vs   <= ~VS_POL;
    end else begin
      r_next_n_d <= r_next_n;
      r_vga_hs   <= w_hs_level;
      r_vga_vs   <= w_vs_level;
    end
  end

  rgb_t w_fb_rgb;
  rgb_t w_dac_rgb;

  assign w_fb_rgb  = '{r: fb.red, g: fb.green, b: fb.blue};
  assign w_dac_rgb = blank_rgb(w_fb_rgb, r_next_n_d);

  assign vga_hs = r_vga_hs;
  assign vga_vs = r_vga_vs;
  assign vga_r  = w_dac_rgb.r;
  assign vga_g  = w_dac_rgb.g;
  assign vga_b  = w_dac_rgb.b;

endmodule
